// File: rtl/pq_arbiter.sv
// Round-robin arbiter sharing one priority_queue between N_REQ requesters.
// One queue operation is outstanding at a time; pop results return to the granted requester.
module pq_arbiter #(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned RD_TIMEOUT  = 15
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0]             req_write,
  input  logic [N_REQ*DATA_LENGTH-1:0] req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [DATA_LENGTH-1:0]       rsp_data,
  output logic                         rsp_err,
  output logic                         q_write,
  output logic                         q_valid,
  output logic [DATA_LENGTH-1:0]       q_data,
  input  logic                         q_full,
  input  logic                         q_empty,
  input  logic                         q_rvalid,
  input  logic [DATA_LENGTH-1:0]       q_rdata,
  output logic                         busy
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] TimeoutLast = 8'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                 state_q, state_d;
  logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]        gnt_q, gnt_d;
  logic                   op_q, op_d;
  logic [DATA_LENGTH-1:0] data_q, data_d;
  logic [7:0]             cnt_q, cnt_d;

  logic [N_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [DATA_LENGTH-1:0] rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   q_write_q, q_write_d;
  logic                   q_valid_q, q_valid_d;
  logic [DATA_LENGTH-1:0] q_data_q, q_data_d;
  logic                   busy_q, busy_d;

  logic [N_REQ-1:0]       elig;
  logic                   gnt_found;
  logic [PtrW-1:0]        gnt_idx;
  logic [PtrW-1:0]        cand;

  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      elig[k] = req_valid[k] & (req_write[k] ? ~q_full : ~q_empty);
    end
  end

  // First eligible requester after rr_ptr, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = PtrW'((32'(rr_ptr_q) + i) % N_REQ);
      if (!gnt_found && elig[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    req_ready   = '0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    q_write_d   = 1'b0;
    q_valid_d   = 1'b0;
    q_data_d    = '0;

    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = ~RST;
          gnt_d     = gnt_idx;
          op_d      = req_write[gnt_idx];
          data_d    = op_d ? req_data[32'(gnt_idx) * DATA_LENGTH +: DATA_LENGTH] : '0;
          rr_ptr_d  = gnt_idx;
          q_valid_d = 1'b1;
          q_write_d = op_d;
          q_data_d  = data_d;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = op_q ? StIdle : StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 8'd1;
        if (q_rvalid) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_data_d         = q_rdata;
          state_d            = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_err_d          = 1'b1;
          state_d            = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      rr_ptr_q    <= PtrW'(N_REQ - 1);
      gnt_q       <= '0;
      op_q        <= 1'b0;
      data_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      q_write_q   <= 1'b0;
      q_valid_q   <= 1'b0;
      q_data_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      q_write_q   <= q_write_d;
      q_valid_q   <= q_valid_d;
      q_data_q    <= q_data_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign q_write   = q_write_q;
  assign q_valid   = q_valid_q;
  assign q_data    = q_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pq_arbiter.sv
// Directed bench for pq_arbiter; the queue side is driven by hand from the stimulus.
module tb_pq_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_write = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             rsp_err;
  logic             q_write;
  logic             q_valid;
  logic [DW-1:0]    q_data;
  logic             q_full = 1'b0;
  logic             q_empty = 1'b1;
  logic             q_rvalid = 1'b0;
  logic [DW-1:0]    q_rdata = '0;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  pq_arbiter #(
    .DATA_LENGTH(DW),
    .N_REQ      (NR),
    .RD_TIMEOUT (15)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_data (req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .q_write  (q_write),
    .q_valid  (q_valid),
    .q_data   (q_data),
    .q_full   (q_full),
    .q_empty  (q_empty),
    .q_rvalid (q_rvalid),
    .q_rdata  (q_rdata),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Lands 2 time units after a rising edge, away from the sampling edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with requests pending to confirm req_ready is held low.
    req_valid = 4'hF;
    req_write = 4'hF;
    q_empty   = 1'b0;
    tick();
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_qvalid", 32'(q_valid), 32'h0);
    check_eq("rst_qdata", q_data, 32'h0);
    check_eq("rst_rspvalid", 32'(rsp_valid), 32'h0);
    req_valid = '0;
    q_empty   = 1'b1;
    do_reset();

    // Single push from requester 0.
    req_valid = 4'b0001;
    req_write = 4'b0001;
    req_data[0 +: DW] = 32'h0000_00A5;
    #1;
    check_eq("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    check_eq("t1_qvalid", 32'(q_valid), 32'h1);
    check_eq("t1_qwrite", 32'(q_write), 32'h1);
    check_eq("t1_qdata", q_data, 32'hA5);
    check_eq("t1_busy_issue", 32'(busy), 32'h1);
    tick();
    check_eq("t1_busy_idle", 32'(busy), 32'h0);
    check_eq("t1_qvalid_off", 32'(q_valid), 32'h0);

    // Continuous pushes from all requesters, fresh round-robin pointer.
    do_reset();
    req_valid = 4'hF;
    req_write = 4'hF;
    for (int k = 0; k < 4; k++) req_data[k*DW +: DW] = 32'h100 + 32'(k);
    for (int n = 0; n < 8; n++) begin
      #1;
      check_eq($sformatf("t2_ready_%0d", n), 32'(req_ready), 32'h1 << (n % 4));
      tick();
      check_eq($sformatf("t2_qdata_%0d", n), q_data, 32'h100 + 32'(n % 4));
      check_eq($sformatf("t2_gap_%0d", n), 32'(req_ready), 32'h0);
      tick();
    end
    req_valid = '0;

    // Pop from requester 2 with a 3-cycle queue read latency.
    q_empty   = 1'b0;
    req_valid = 4'b0100;
    req_write = 4'b0000;
    #1;
    check_eq("t3_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    check_eq("t3_qvalid", 32'(q_valid), 32'h1);
    check_eq("t3_qwrite", 32'(q_write), 32'h0);
    check_eq("t3_qdata", q_data, 32'h0);
    tick();
    check_eq("t3_busy_wait", 32'(busy), 32'h1);
    tick();
    tick();
    q_rvalid = 1'b1;
    q_rdata  = 32'h1234;
    tick();
    q_rvalid = 1'b0;
    check_eq("t3_rspvalid", 32'(rsp_valid), 32'h4);
    check_eq("t3_rspdata", rsp_data, 32'h1234);
    check_eq("t3_rsperr", 32'(rsp_err), 32'h0);
    check_eq("t3_busy_done", 32'(busy), 32'h0);
    tick();
    check_eq("t3_rsp_pulse", 32'(rsp_valid), 32'h0);

    // Empty queue: pop from 1 blocked, push from 3 proceeds.
    q_empty   = 1'b1;
    req_valid = 4'b1010;
    req_write = 4'b1000;
    req_data[3*DW +: DW] = 32'hBEEF;
    #1;
    check_eq("t4_ready3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0010;
    check_eq("t4_qwrite", 32'(q_write), 32'h1);
    check_eq("t4_qdata", q_data, 32'hBEEF);
    tick();
    #1;
    check_eq("t4_blocked_a", 32'(req_ready), 32'h0);
    tick();
    #1;
    check_eq("t4_blocked_b", 32'(req_ready), 32'h0);
    q_empty = 1'b0;
    #1;
    check_eq("t4_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check_eq("t4_pop_qwrite", 32'(q_write), 32'h0);
    tick();
    q_rvalid = 1'b1;
    q_rdata  = 32'h55;
    tick();
    q_rvalid = 1'b0;
    check_eq("t4_rspvalid", 32'(rsp_valid), 32'h2);
    check_eq("t4_rspdata", rsp_data, 32'h55);

    // Pop that never returns data: times out after 15 WAIT cycles.
    q_rdata   = 32'hDEAD;
    req_valid = 4'b0001;
    req_write = 4'b0000;
    #1;
    check_eq("t5_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    for (int i = 1; i < 15; i++) begin
      tick();
      check_eq($sformatf("t5_wait_%0d", i), 32'(rsp_valid), 32'h0);
    end
    tick();
    check_eq("t5_rspvalid", 32'(rsp_valid), 32'h1);
    check_eq("t5_rsperr", 32'(rsp_err), 32'h1);
    check_eq("t5_rspdata", rsp_data, 32'h0);
    check_eq("t5_busy", 32'(busy), 32'h0);
    tick();
    check_eq("t5_err_pulse", 32'(rsp_err), 32'h0);

    // Reset in the middle of a pop.
    req_valid = 4'b0010;
    #1;
    check_eq("t6_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    tick();
    check_eq("t6_busy_wait", 32'(busy), 32'h1);
    RST = 1'b1;
    #1;
    check_eq("t6_busy_rst", 32'(busy), 32'h0);
    check_eq("t6_qvalid_rst", 32'(q_valid), 32'h0);
    check_eq("t6_rsp_rst", 32'(rsp_valid), 32'h0);
    tick();
    RST      = 1'b0;
    q_rvalid = 1'b1;
    q_rdata  = 32'h77;
    tick();
    q_rvalid = 1'b0;
    check_eq("t6_no_rsp", 32'(rsp_valid), 32'h0);
    check_eq("t6_idle", 32'(busy), 32'h0);
    req_valid = 4'hF;
    req_write = 4'hF;
    q_full    = 1'b0;
    #1;
    check_eq("t6_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pq_arbiter.md
Name: pq_arbiter

Overview:
- Shares one priority_queue instance between N_REQ independent requesters, each issuing push (write) or pop (read) operations.
- Arbitrates round-robin among requesters whose operation can currently succeed, and drives the queue's i_write/i_valid/i_data.
- Waits for the queue's o_valid on pops and routes the popped word back to the granted requester.
- Sits directly in front of priority_queue; requesters never touch the queue ports.

Parameters:
- DATA_LENGTH, 32, width of queue data words.
- N_REQ, 4, number of requesters (2..16).
- RD_TIMEOUT, 15, maximum WAIT cycles for queue o_valid before a pop is failed (1..255).

Ports:
- CLK  in  1  clock; all logic rising-edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operation pending; held until accepted.
- req_write  in  N_REQ  per-requester op type: 1 push, 0 pop; stable while req_valid.
- req_data  in  N_REQ*DATA_LENGTH  push data; requester k uses bits [k*DATA_LENGTH +: DATA_LENGTH].
- req_ready  out  N_REQ  one-hot accept pulse; the op is accepted when req_valid[k] & req_ready[k].
- rsp_valid  out  N_REQ  one-hot, one-cycle pop-completion pulse to the granted requester.
- rsp_data  out  DATA_LENGTH  popped word; valid only with a rsp_valid bit.
- rsp_err  out  1  with rsp_valid: 1 = pop timed out, rsp_data = 0.
- q_write  out  1  to queue i_write.
- q_valid  out  1  to queue i_valid.
- q_data  out  DATA_LENGTH  to queue i_data.
- q_full  in  1  from queue o_full.
- q_empty  in  1  from queue o_empty.
- q_rvalid  in  1  from queue o_valid.
- q_rdata  in  DATA_LENGTH  from queue o_data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=N_REQ-1 (requester 0 has first priority), timeout counter=0.
- Reset values: all registered outputs 0, i.e. rsp_valid, rsp_data, rsp_err, q_write, q_valid, q_data and busy. req_ready is 0 while RST is high.
- Eligibility: elig[k] = req_valid[k] & (req_write[k] ? ~q_full : ~q_empty). Ineligible requests stay pending and are not dropped.
- IDLE:
  - If elig is nonzero, grant g = the first set bit of elig searching from rr_ptr+1 upward with wrap.
  - Assert req_ready[g] combinationally in this cycle.
  - Register g, req_write[g] and req_data[g]; set rr_ptr=g; go to ISSUE.
  - If elig is zero, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - q_valid=1, q_write=latched op, q_data=latched data (0 for pop).
  - Next state is IDLE for a push, WAIT for a pop (counter cleared).
- WAIT:
  - q_valid=0; the counter increments each cycle.
  - If q_rvalid=1: the next cycle presents rsp_valid[g]=1, rsp_data=q_rdata, rsp_err=0; go to IDLE.
  - Else if counter reaches RD_TIMEOUT: the next cycle presents rsp_valid[g]=1, rsp_err=1, rsp_data=0; go to IDLE.
  - If q_rvalid and the timeout coincide, q_rvalid wins.
- rsp_* are registered one-cycle pulses coinciding with the return to IDLE. A new grant may be issued in that same IDLE cycle.
- Only one queue operation is outstanding at a time. Throughput is 1 push per 2 cycles and 1 pop per 3+L cycles, where L is queue read latency.
- Full/empty flags are sampled only in IDLE, at least one cycle after the previous ISSUE, so the queue flags are current.
- A push while the queue is full or a pop while it is empty is never issued.
- q_rvalid outside WAIT is ignored.
- Deassertion of req_valid by a requester before acceptance is legal, and it simply drops out of elig.
- Reset asserted in WAIT abandons the pop with no rsp_valid. The requester's req_valid handshake already completed; recovery is the system's responsibility.
- rr_ptr updates only on grant; a requester that is continuously eligible is granted within N_REQ grants.

Test Plan:
- Reset, then req_valid=0001 push 0x0000_00A5 with q_full=0 -> req_ready=0001 same cycle; next cycle q_valid=1, q_write=1, q_data=0xA5; busy then low.
- All 4 requesters push continuously -> grant order 0,1,2,3,0,..., one grant every 2 cycles, no requester skipped.
- Requester 2 pops, queue returns q_rvalid with q_rdata=0x1234 three cycles after ISSUE -> rsp_valid=0100, rsp_data=0x1234, rsp_err=0 the following cycle.
- q_empty=1 with requester 1 popping and requester 3 pushing -> only requester 3 granted. Requester 1 is granted after q_empty falls.
- Pop with q_rvalid never asserted, RD_TIMEOUT=15 -> rsp_valid for the granted requester with rsp_err=1 and rsp_data=0, 15 cycles after entering WAIT; return to IDLE.
- RST pulsed mid-WAIT -> all outputs 0 immediately; no rsp_valid afterward; next grant goes to requester 0 when all are eligible.
